// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register with valid/ready
// handshake, flush-to-bubble and a saturating bubble counter.
// Build option PIPE_SKID_EN: adds a skid entry behind the main register so that
// in_ready is a registered signal. Without it the stage is a single register
// with a combinational in_ready.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_EMPTY | no beat held, out_valid=0, channel 0 shows NOP_VAL
// ST_FULL  | (single-register build) main register holds the output beat
// ST_ONE   | (skid build) main register holds the output beat, skid empty
// ST_TWO   | (skid build) main and skid both hold beats, in_ready=0
module pipe_stage_reg #(
    parameter int               WIDTH    = 32,
    parameter int               CHANNELS = 8,
    parameter logic [WIDTH-1:0] NOP_VAL  = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [15:0]               bubble_cnt
);

    localparam int DW = CHANNELS * WIDTH;

`ifdef PIPE_SKID_EN
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;
`else
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;
`endif

    state_t          state_q;
    state_t          state_d;
    logic            out_valid_q;
    logic [DW-1:0]   main_q;
    logic            ld_main_in;
    logic            clr_ch0;
    logic            accept;
    logic            emit;

`ifdef PIPE_SKID_EN
    logic [DW-1:0]   skid_q;
    logic            ld_main_skid;
    logic            ld_skid;
    logic            in_ready_q;
`endif

    assign accept    = in_valid & in_ready;
    assign emit      = out_valid_q & out_ready;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

`ifdef PIPE_SKID_EN
    // Registered ready: only the TWO state refuses, regardless of out_ready now.
    assign in_ready = in_ready_q;

    // Next-state and datapath load selects for the two-entry buffer.
    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        clr_ch0      = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d    = ST_ONE;
                    ld_main_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && emit) begin
                    ld_main_in = 1'b1;
                end else if (accept) begin
                    state_d = ST_TWO;
                    ld_skid = 1'b1;
                end else if (emit) begin
                    state_d = ST_EMPTY;
                    clr_ch0 = 1'b1;
                end
            end
            ST_TWO: begin
                if (emit) begin
                    state_d      = ST_ONE;
                    ld_main_skid = 1'b1;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Ready register tracks the next state so it is known a cycle ahead.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= (state_d != ST_TWO);
        end
    end

    // Skid entry captures the second beat while the main register is stalled.
    always_ff @(posedge clk) begin
        if (!reset) begin
            skid_q <= '0;
        end else if (ld_skid && !flush) begin
            skid_q <= in_data;
        end
    end
`else
    // Single register can take a new beat whenever it is empty or draining.
    assign in_ready = !out_valid_q | out_ready;

    // Next-state and datapath load selects for the single-register stage.
    always_comb begin
        state_d    = state_q;
        ld_main_in = 1'b0;
        clr_ch0    = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d    = ST_FULL;
                    ld_main_in = 1'b1;
                end
            end
            ST_FULL: begin
                if (accept) begin
                    ld_main_in = 1'b1;
                end else if (emit) begin
                    state_d = ST_EMPTY;
                    clr_ch0 = 1'b1;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end
`endif

    // State and output-valid registers; reset and flush both return to EMPTY.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_d != ST_EMPTY);
        end
    end

    // Main payload register: channel 0 becomes NOP_VAL whenever the stage empties,
    // the remaining channels keep their last value except on reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            main_q             <= '0;
            main_q[WIDTH-1:0]  <= NOP_VAL;
        end else if (flush || clr_ch0) begin
            main_q[WIDTH-1:0]  <= NOP_VAL;
        end else if (ld_main_in) begin
            main_q             <= in_data;
`ifdef PIPE_SKID_EN
        end else if (ld_main_skid) begin
            main_q             <= skid_q;
`endif
        end
    end

    // Saturating count of cycles where downstream was ready but nothing was offered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bubble_cnt <= '0;
        end else if (out_ready && !out_valid_q && (bubble_cnt != 16'hFFFF)) begin
            bubble_cnt <= bubble_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: directed stimulus, scoreboard queue filled at
// each accepted beat and drained by a monitor on every emitted beat.
module tb_pipe_stage_reg;

    localparam int W  = 32;
    localparam int CH = 8;
    localparam int DW = W * CH;
    localparam logic [W-1:0] NOP = 32'h00000000;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [15:0]   bubble_cnt;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] sb_q[$];

    pipe_stage_reg #(
        .WIDTH    (W),
        .CHANNELS (CH),
        .NOP_VAL  (NOP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0b exp=%0b", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic chk_32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic chk_d(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat(input logic [31:0] c0, input logic [31:0] c1);
        logic [DW-1:0] b;
        b = '0;
        b[31:0]  = c0;
        b[63:32] = c1;
        for (int k = 2; k < CH; k++) begin
            b[k*W +: W] = c0 + (32'h01010101 * k);
        end
        return b;
    endfunction

    function automatic logic [DW-1:0] with_nop(input logic [DW-1:0] b);
        logic [DW-1:0] r;
        r = b;
        r[W-1:0] = NOP;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat, holding it until the stage takes it or the budget runs out.
    task automatic send(input string name, input logic [DW-1:0] d, input int max_cyc);
        logic a;
        bit   done;
        done = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < max_cyc && !done; i++) begin
            @(negedge clk);
            a = in_ready;
            @(posedge clk);
            #1;
            if (a) done = 1'b1;
        end
        in_valid = 1'b0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s accept timeout act=not_accepted exp=accepted", name);
        end
    endtask

    task automatic do_reset(input int n);
        reset     = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (n) step();
        reset = 1'b1;
        step();
    endtask

    // Monitor: compare each emitted beat with the scoreboard head; track accepts.
    initial begin : monitor
        logic          pend_acc;
        logic          pend_clr;
        logic [DW-1:0] pend_data;
        logic [DW-1:0] exp;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected act=%0h exp=no_beat", out_data);
                end else begin
                    exp = sb_q.pop_front();
                    chk_d("sb_data", out_data, exp);
                end
            end
            pend_acc  = (reset === 1'b1) && (flush === 1'b0) &&
                        (in_valid === 1'b1) && (in_ready === 1'b1);
            pend_clr  = (reset !== 1'b1) || (flush === 1'b1);
            pend_data = in_data;
            @(posedge clk);
            if (pend_clr) sb_q.delete();
            if (pend_acc) sb_q.push_back(pend_data);
        end
    end

    initial begin : stim
        logic [DW-1:0] b0, b1, b2, ba, bb, bc, bd, be, bf, bg;
        b0 = beat(32'h8C010004, 32'h00400000);
        b1 = beat(32'h8C020008, 32'h00400004);
        b2 = beat(32'h00221820, 32'h00400008);
        ba = beat(32'h11110001, 32'h00003000);
        bb = beat(32'h22220002, 32'h00003000);
        bc = beat(32'h33330003, 32'h00005000);
        bd = beat(32'h44440004, 32'h00005004);
        be = beat(32'h55550005, 32'h00005008);
        bf = beat(32'h66660006, 32'h0000500C);
        bg = beat(32'h77770007, 32'h00006000);

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // 1: reset held two cycles, then released
        do_reset(2);
        chk_b("rst_out_valid", out_valid, 1'b0);
        chk_d("rst_out_data", out_data, '0);
        chk_b("rst_in_ready", in_ready, 1'b1);
        chk_w("rst_bubble", bubble_cnt, 16'd0);

        // 2: back-to-back stream
        out_ready = 1'b1;
        send("stream_b0", b0, 3);
        chk_b("stream_v0", out_valid, 1'b1);
        chk_d("stream_d0", out_data, b0);
        send("stream_b1", b1, 3);
        chk_b("stream_v1", out_valid, 1'b1);
        chk_d("stream_d1", out_data, b1);
        send("stream_b2", b2, 3);
        chk_b("stream_v2", out_valid, 1'b1);
        chk_d("stream_d2", out_data, b2);
        step();
        chk_b("stream_drain_v", out_valid, 1'b0);
        chk_d("stream_drain_nop", out_data, with_nop(b2));

        // 3: downstream stall
        out_ready = 1'b0;
        send("stall_a", ba, 3);
`ifdef PIPE_SKID_EN
        chk_b("stall_rdy_after_a", in_ready, 1'b1);
        chk_d("stall_hold_a", out_data, ba);
        send("stall_b", bb, 3);
        chk_b("stall_rdy_after_b", in_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_d("stall_hold", out_data, ba);
            chk_b("stall_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        step();
        chk_b("release_v_b", out_valid, 1'b1);
        chk_d("release_d_b", out_data, bb);
`else
        chk_b("stall_rdy_after_a", in_ready, 1'b0);
        in_valid = 1'b1;
        in_data  = bb;
        for (int i = 0; i < 4; i++) begin
            chk_d("stall_hold", out_data, ba);
            chk_b("stall_valid", out_valid, 1'b1);
            chk_b("stall_rdy", in_ready, 1'b0);
            step();
        end
        out_ready = 1'b1;
        send("release_b", bb, 3);
        chk_b("release_v_b", out_valid, 1'b1);
        chk_d("release_d_b", out_data, bb);
`endif
        step();
        chk_b("release_drain_v", out_valid, 1'b0);
        chk_d("release_drain_nop", out_data, with_nop(bb));

        // 4: flush while stalled with held beat(s)
        out_ready = 1'b0;
        send("flush_c", bc, 3);
`ifdef PIPE_SKID_EN
        send("flush_d", bd, 3);
        chk_b("flush_two_rdy", in_ready, 1'b0);
        in_data = be;
`else
        in_data = bd;
`endif
        in_valid = 1'b1;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk_b("flush_out_valid", out_valid, 1'b0);
        chk_32("flush_ch0_nop", out_data[W-1:0], NOP);
        chk_b("flush_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_b("flush_stays_empty", out_valid, 1'b0);
        end
        // flush on the same edge as an accept drops the incoming beat
        in_valid = 1'b1;
        in_data  = bf;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk_b("flush_acc_v", out_valid, 1'b0);
        chk_32("flush_acc_ch0", out_data[W-1:0], NOP);
        step();
        chk_b("flush_acc_v2", out_valid, 1'b0);

        // 5: bubble counting and saturation
        do_reset(2);
        chk_w("bubble_after_rst", bubble_cnt, 16'd0);
        out_ready = 1'b1;
        repeat (10) step();
        chk_w("bubble_10", bubble_cnt, 16'd10);
        repeat (65525) step();
        chk_w("bubble_65535", bubble_cnt, 16'hFFFF);
        repeat (4465) step();
        chk_w("bubble_sat", bubble_cnt, 16'hFFFF);

        // 6: reset and flush on the same edge as an offered beat
        send("pre_rst_g", bg, 3);
        chk_d("pre_rst_d", out_data, bg);
        reset    = 1'b0;
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = bb;
        step();
        reset    = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk_b("rvf_out_valid", out_valid, 1'b0);
        chk_d("rvf_out_data", out_data, '0);
        chk_w("rvf_bubble", bubble_cnt, 16'd0);
        chk_b("rvf_in_ready", in_ready, 1'b1);
        step();
        chk_b("rvf_dropped", out_valid, 1'b0);

        step();
        chk_32("sb_drained", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
